// File: rtl/pic_priority_ctrl.sv
// PIC request/in-service controller: IRR latch, IMR mask, nested priority, two-pulse INTA, vector out.
// Build option: define PIC_ROTATE_EN for automatic rotation on EOI (otherwise fixed IR7 > ... > IR0).
module pic_priority_ctrl #(
    parameter int unsigned EDGE_TRIG = 1,
    parameter logic [4:0]  VEC_BASE  = 5'h08
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] ir,
    input  logic       imr_wr,
    input  logic [7:0] imr_data,
    input  logic       eoi,
    input  logic       inta,
    output logic       int_o,
    output logic [7:0] vec_o,
    output logic       vec_valid,
    output logic [7:0] irr_o,
    output logic [7:0] isr_o,
    output logic [7:0] imr_o
);

    localparam int unsigned NUM_IR = 8;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] ACK1 = 2'd2;

    logic [1:0] state_q, state_d;
    logic [7:0] ir_q, ir_d;
    logic [7:0] irr_q, irr_d;
    logic [7:0] isr_q, isr_d;
    logic [7:0] imr_q, imr_d;
    logic [2:0] id_q, id_d;
    logic       int_q, int_d;
    logic [7:0] vec_q, vec_d;
    logic       vec_valid_q, vec_valid_d;
    logic [2:0] prio_ptr;

    logic [3:0] isr_top, elig_top, post_top;
    logic [7:0] elig, isr_post;
    logic [2:0] eoi_id, win_id;
    logic       eoi_hit, win_valid, grant;

    // Returns {found, rank} of the highest-priority set bit; rank 7 is the bit just below ptr.
    function automatic logic [3:0] top_rank(input logic [7:0] v, input logic [2:0] ptr);
        logic [3:0] res;
        logic [2:0] idx;
        res = 4'd0;
        for (int k = 0; k < int'(NUM_IR); k++) begin
            idx = 3'(k) + ptr;
            if (v[idx]) res = {1'b1, 3'(k)};
        end
        return res;
    endfunction

`ifdef PIC_ROTATE_EN
    logic [2:0] prio_ptr_q, prio_ptr_d;

    always_comb begin
        prio_ptr_d = prio_ptr_q;
        if (eoi_hit) prio_ptr_d = eoi_id;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) prio_ptr_q <= 3'd0;
        else     prio_ptr_q <= prio_ptr_d;
    end

    assign prio_ptr = prio_ptr_q;
`else
    assign prio_ptr = 3'd0;
`endif

    // EOI is applied before the grant, so the winner is judged against the post-EOI ISR.
    always_comb begin
        isr_top  = top_rank(isr_q, prio_ptr);
        eoi_hit  = eoi && isr_top[3];
        eoi_id   = isr_top[2:0] + prio_ptr;
        isr_post = isr_q;
        if (eoi_hit) isr_post[eoi_id] = 1'b0;
        elig      = irr_q & ~imr_q;
        elig_top  = top_rank(elig, prio_ptr);
        post_top  = top_rank(isr_post, prio_ptr);
        win_valid = elig_top[3] && (!post_top[3] || (elig_top[2:0] > post_top[2:0]));
        win_id    = elig_top[2:0] + prio_ptr;
    end

    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        int_d       = int_q;
        vec_d       = vec_q;
        vec_valid_d = 1'b0;
        grant       = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_valid) begin
                    state_d = REQ;
                    int_d   = 1'b1;
                end
            end
            REQ: begin
                if (inta) begin
                    state_d = ACK1;
                    if (win_valid) begin
                        grant = 1'b1;
                        id_d  = win_id;
                    end else begin
                        id_d  = 3'd7;
                    end
                end else if (!win_valid) begin
                    state_d = IDLE;
                    int_d   = 1'b0;
                end
            end
            ACK1: begin
                if (inta) begin
                    vec_d       = {VEC_BASE, id_q};
                    vec_valid_d = 1'b1;
                    int_d       = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                int_d   = 1'b0;
            end
        endcase
    end

    // Edge mode: a new edge beats a same-cycle grant clear on the same bit.
    always_comb begin
        ir_d  = ir;
        imr_d = imr_wr ? imr_data : imr_q;
        isr_d = isr_post;
        if (grant) isr_d[win_id] = 1'b1;
        if (EDGE_TRIG != 0) begin
            irr_d = irr_q;
            if (grant) irr_d[win_id] = 1'b0;
            irr_d = irr_d | (ir & ~ir_q);
        end else begin
            irr_d = ir;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ir_q        <= 8'd0;
            irr_q       <= 8'd0;
            isr_q       <= 8'd0;
            imr_q       <= 8'd0;
            id_q        <= 3'd0;
            int_q       <= 1'b0;
            vec_q       <= 8'd0;
            vec_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ir_q        <= ir_d;
            irr_q       <= irr_d;
            isr_q       <= isr_d;
            imr_q       <= imr_d;
            id_q        <= id_d;
            int_q       <= int_d;
            vec_q       <= vec_d;
            vec_valid_q <= vec_valid_d;
        end
    end

    assign int_o     = int_q;
    assign vec_o     = vec_q;
    assign vec_valid = vec_valid_q;
    assign irr_o     = irr_q;
    assign isr_o     = isr_q;
    assign imr_o     = imr_q;

endmodule

// File: tb/tb_pic_priority_ctrl.sv
// Bench for pic_priority_ctrl: an edge-mode and a level-mode instance share stimulus; vectors go through a queue.
module tb_pic_priority_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] ir = 8'd0;
    logic       imr_wr = 1'b0;
    logic [7:0] imr_data = 8'd0;
    logic       eoi = 1'b0;
    logic       inta = 1'b0;

    logic       e_int, e_vv, l_int, l_vv;
    logic [7:0] e_vec, e_irr, e_isr, e_imr, l_vec, l_irr, l_isr, l_imr;

    logic       sel_level = 1'b0;
    logic       vec_window = 1'b0;
    int         n_checks = 0;
    int         n_fail = 0;
    int         unexp = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    pic_priority_ctrl #(.EDGE_TRIG(1), .VEC_BASE(5'h08)) dut_e (
        .clk(clk), .rst(rst), .ir(ir), .imr_wr(imr_wr), .imr_data(imr_data), .eoi(eoi), .inta(inta),
        .int_o(e_int), .vec_o(e_vec), .vec_valid(e_vv), .irr_o(e_irr), .isr_o(e_isr), .imr_o(e_imr)
    );

    pic_priority_ctrl #(.EDGE_TRIG(0), .VEC_BASE(5'h08)) dut_l (
        .clk(clk), .rst(rst), .ir(ir), .imr_wr(imr_wr), .imr_data(imr_data), .eoi(eoi), .inta(inta),
        .int_o(l_int), .vec_o(l_vec), .vec_valid(l_vv), .irr_o(l_irr), .isr_o(l_isr), .imr_o(l_imr)
    );

    logic       o_int, o_vv;
    logic [7:0] o_vec, o_irr, o_isr, o_imr;
    assign o_int = sel_level ? l_int : e_int;
    assign o_vv  = sel_level ? l_vv  : e_vv;
    assign o_vec = sel_level ? l_vec : e_vec;
    assign o_irr = sel_level ? l_irr : e_irr;
    assign o_isr = sel_level ? l_isr : e_isr;
    assign o_imr = sel_level ? l_imr : e_imr;

    // Any vector strobe outside an expected window is a spurious response.
    always @(negedge clk) begin
        if (!rst && o_vv && !vec_window) unexp = unexp + 1;
    end

    typedef struct {
        logic [7:0] ir;
        logic [7:0] imr;
        logic       exp_int;
        logic [7:0] exp_vec;
        logic [7:0] exp_isr;
        logic [7:0] exp_irr;
    } vec_t;

    vec_t tbl[8];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", nm, act, exp);
        end
    endtask

    task automatic do_reset;
        ir = 8'd0; imr_wr = 1'b0; eoi = 1'b0; inta = 1'b0;
        rst = 1'b1;
        ticks(2);
        rst = 1'b0;
        tick();
    endtask

    task automatic pulse_ir(input logic [7:0] v);
        ir = v; tick(); ir = 8'd0;
    endtask

    task automatic pulse_eoi;
        eoi = 1'b1; tick(); eoi = 1'b0;
    endtask

    task automatic write_imr(input logic [7:0] v);
        imr_wr = 1'b1; imr_data = v; tick(); imr_wr = 1'b0;
    endtask

    task automatic inta1;
        inta = 1'b1; tick(); inta = 1'b0;
    endtask

    // Second acknowledge: push the expected vector, then pop it against the DUT strobe.
    task automatic inta2(input logic [7:0] exp, input string nm);
        logic       got;
        logic [7:0] ev;
        vec_window = 1'b1;
        exp_q.push_back(exp);
        inta = 1'b1; tick(); inta = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (o_vv) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        ev = exp_q.pop_front();
        if (got) chk(nm, o_vec, ev);
        else begin
            n_checks++; n_fail++;
            $display("FAIL %s: no vec_valid within bound, expected %02h", nm, ev);
        end
        tick();
        vec_window = 1'b0;
    endtask

    logic [7:0] rot_vec, rot_isr;

    initial begin
        tbl[0] = '{8'h08, 8'h00, 1'b1, 8'h43, 8'h08, 8'h00};
        tbl[1] = '{8'h24, 8'h00, 1'b1, 8'h45, 8'h20, 8'h04};
        tbl[2] = '{8'h81, 8'h00, 1'b1, 8'h47, 8'h80, 8'h01};
        tbl[3] = '{8'h01, 8'h00, 1'b1, 8'h40, 8'h01, 8'h00};
        tbl[4] = '{8'hFF, 8'h80, 1'b1, 8'h46, 8'h40, 8'hBF};
        tbl[5] = '{8'h08, 8'h08, 1'b0, 8'h00, 8'h00, 8'h08};
        tbl[6] = '{8'hF0, 8'hF0, 1'b0, 8'h00, 8'h00, 8'hF0};
        tbl[7] = '{8'h03, 8'h01, 1'b1, 8'h41, 8'h02, 8'h01};

        #1;
        chk("reset_int", {7'd0, e_int}, 8'h00);
        chk("reset_vv", {7'd0, e_vv}, 8'h00);
        chk("reset_vec", e_vec, 8'h00);
        do_reset();
        chk("reset_isr", e_isr, 8'h00);
        chk("reset_irr", e_irr, 8'h00);
        chk("reset_imr", e_imr, 8'h00);

        // Table: single request pattern under a mask, full acknowledge where a winner exists.
        for (int t = 0; t < 8; t++) begin
            do_reset();
            write_imr(tbl[t].imr);
            ir = tbl[t].ir; tick(); ir = 8'd0;
            chk($sformatf("tbl%0d_int_1edge", t), {7'd0, o_int}, 8'h00);
            tick();
            chk($sformatf("tbl%0d_int", t), {7'd0, o_int}, {7'd0, tbl[t].exp_int});
            if (tbl[t].exp_int) begin
                inta1();
                chk($sformatf("tbl%0d_isr", t), o_isr, tbl[t].exp_isr);
                chk($sformatf("tbl%0d_irr", t), o_irr, tbl[t].exp_irr);
                chk($sformatf("tbl%0d_int_ack1", t), {7'd0, o_int}, 8'h01);
                inta2(tbl[t].exp_vec, $sformatf("tbl%0d_vec", t));
            end else begin
                chk($sformatf("tbl%0d_irr", t), o_irr, tbl[t].exp_irr);
                chk($sformatf("tbl%0d_isr", t), o_isr, tbl[t].exp_isr);
            end
        end

        // Two simultaneous requests, EOI hands over, then nesting above the in-service level.
        do_reset();
        pulse_ir(8'h24); tick();
        inta1(); inta2(8'h45, "dual_first_vec");
        chk("dual_int_blocked", {7'd0, o_int}, 8'h00);
        pulse_eoi();
        chk("dual_isr_eoi", o_isr, 8'h00);
        chk("dual_int_second", {7'd0, o_int}, 8'h01);
        inta1(); inta2(8'h42, "dual_second_vec");
        chk("nest_isr_ir2", o_isr, 8'h04);
        pulse_ir(8'h02); tick();
        chk("nest_low_int", {7'd0, o_int}, 8'h00);
        chk("nest_low_irr", o_irr, 8'h02);
        pulse_ir(8'h40); tick();
        chk("nest_high_int", {7'd0, o_int}, 8'h01);
        inta1();
        chk("nest_isr", o_isr, 8'h44);
        inta2(8'h46, "nest_vec");
        pulse_eoi();
        chk("nest_eoi_isr", o_isr, 8'h04);
        chk("nest_eoi_int", {7'd0, o_int}, 8'h00);

        // EOI and first INTA on the same edge; then masking an in-service bit.
        do_reset();
        pulse_ir(8'h20); tick();
        inta1(); inta2(8'h45, "eoigrant_first_vec");
        pulse_ir(8'h40); tick();
        chk("eoigrant_int", {7'd0, o_int}, 8'h01);
        eoi = 1'b1; inta = 1'b1; tick(); eoi = 1'b0; inta = 1'b0;
        chk("eoigrant_isr", o_isr, 8'h40);
        chk("eoigrant_irr", o_irr, 8'h00);
        inta2(8'h46, "eoigrant_vec");
        write_imr(8'hFF);
        chk("mask_isr_kept", o_isr, 8'h40);
        chk("mask_imr", o_imr, 8'hFF);

        // Masking the winner in REQ: another eligible request takes over, else int_o drops.
        do_reset();
        pulse_ir(8'h0A); tick();
        chk("reqmask_int", {7'd0, o_int}, 8'h01);
        write_imr(8'h08); tick();
        chk("reqmask_int_kept", {7'd0, o_int}, 8'h01);
        inta1(); inta2(8'h41, "reqmask_vec");
        chk("reqmask_isr", o_isr, 8'h02);
        do_reset();
        pulse_ir(8'h08); tick();
        write_imr(8'h08); tick();
        chk("reqmask_drop", {7'd0, o_int}, 8'h00);
        inta1(); tick();
        chk("stray_inta_isr", o_isr, 8'h00);

        // Masked pending request released by an IMR write.
        do_reset();
        write_imr(8'h08);
        pulse_ir(8'h08); ticks(2);
        chk("imr_pend_irr", o_irr, 8'h08);
        chk("imr_pend_int", {7'd0, o_int}, 8'h00);
        write_imr(8'h00);
        chk("imr_clear", o_imr, 8'h00);
        tick();
        chk("imr_release_int", {7'd0, o_int}, 8'h01);

        // Level mode: grant leaves IRR, withdrawal drops int_o, INTA without winner is spurious.
        sel_level = 1'b1;
        do_reset();
        ir = 8'h10; ticks(2);
        chk("lvl_int", {7'd0, o_int}, 8'h01);
        inta1();
        chk("lvl_isr", o_isr, 8'h10);
        chk("lvl_irr_kept", o_irr, 8'h10);
        inta2(8'h44, "lvl_vec");
        do_reset();
        ir = 8'h10; ticks(2); ir = 8'h00; ticks(2);
        chk("lvl_withdraw", {7'd0, o_int}, 8'h00);
        ir = 8'h10; ticks(2); ir = 8'h00; tick();
        chk("lvl_req_held", {7'd0, o_int}, 8'h01);
        inta1();
        chk("spur_isr", o_isr, 8'h00);
        inta2(8'h47, "spur_vec");
        chk("spur_int", {7'd0, o_int}, 8'h00);
        sel_level = 1'b0;

        // After servicing IR7: rotation makes IR0 win over IR7, fixed order keeps IR7; then reset in ACK1.
`ifdef PIC_ROTATE_EN
        rot_vec = 8'h40; rot_isr = 8'h01;
`else
        rot_vec = 8'h47; rot_isr = 8'h80;
`endif
        do_reset();
        pulse_ir(8'h80); tick();
        inta1(); inta2(8'h47, "rot_ir7_vec");
        pulse_eoi();
        chk("rot_eoi_isr", o_isr, 8'h00);
        pulse_ir(8'h81); tick();
        chk("rot_int", {7'd0, o_int}, 8'h01);
        inta1();
        chk("rot_isr", o_isr, rot_isr);
        inta2(rot_vec, "rot_vec");
        pulse_ir(8'h10); tick();
        inta1();
        rst = 1'b1; #1;
        chk("rst_ack1_int", {7'd0, o_int}, 8'h00);
        chk("rst_ack1_vv", {7'd0, o_vv}, 8'h00);
        chk("rst_ack1_vec", o_vec, 8'h00);
        chk("rst_ack1_isr", o_isr, 8'h00);
        chk("rst_ack1_irr", o_irr, 8'h00);
        chk("rst_ack1_imr", o_imr, 8'h00);
        tick(); rst = 1'b0; ticks(2);
        chk("rst_ack1_no_vec_after", {7'd0, o_vv}, 8'h00);

        chk("unexpected_vec_strobes", 8'(unexp), 8'h00);
        chk("scoreboard_empty", 8'(exp_q.size()), 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
